// File: rtl/led_pkg.sv
// Shared constants for the LED pattern sequencer: mode encodings,
// LED bank width, breathe PWM width and the per-mode starting patterns.
package led_pkg;

   localparam int LED_W         = 4;
   localparam int PWM_WIDTH_DEF = 4;

   localparam logic [1:0] MODE_BIN     = 2'd0;
   localparam logic [1:0] MODE_RUN     = 2'd1;
   localparam logic [1:0] MODE_BOUNCE  = 2'd2;
   localparam logic [1:0] MODE_BREATHE = 2'd3;

   typedef enum logic [1:0] {
      S_BIN     = MODE_BIN,
      S_RUN     = MODE_RUN,
      S_BOUNCE  = MODE_BOUNCE,
      S_BREATHE = MODE_BREATHE
   } mode_e;

   // Pattern register contents on mode entry (count, one-hot, bounce position)
   localparam logic [LED_W-1:0] INIT_BIN    = 4'b0000;
   localparam logic [LED_W-1:0] INIT_RUN    = 4'b0001;
   localparam logic [LED_W-1:0] INIT_BOUNCE = 4'b0000;

   // Pattern register value a freshly entered mode starts from
   function automatic logic [LED_W-1:0] init_pat(input mode_e mode);
      logic [LED_W-1:0] pat;
      case (mode)
         S_BIN:    pat = INIT_BIN;
         S_RUN:    pat = INIT_RUN;
         S_BOUNCE: pat = INIT_BOUNCE;
         default:  pat = 4'b0000;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Control/status bundle of the LED sequencer: button, pause and speed in,
// LED drive, current mode and step pulse out.
interface led_seq_ctrl_if;
   import led_pkg::*;

   logic             i_next;
   logic             i_pause;
   logic [1:0]       i_speed;
   logic [LED_W-1:0] o_led;
   logic [1:0]       o_mode;
   logic             o_tick;

   modport master (output i_next, i_pause, i_speed, input o_led, o_mode, o_tick);
   modport slave  (input i_next, i_pause, i_speed, output o_led, o_mode, o_tick);

endinterface

// File: rtl/led_tick_gen.sv
// Pattern-step prescaler: emits a registered one-cycle pulse every
// (TICK_DIV >> speed) cycles. The >= compare means a mid-count speed-up
// ticks on the next cycle rather than wrapping through the full range.
module led_tick_gen #(
   parameter int TICK_DIV  = 12500000,
   parameter int CNT_WIDTH = 26
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic       i_clr,
   input  logic [1:0] i_speed,
   output logic       o_tick
);

   logic [CNT_WIDTH-1:0] cnt_r;
   logic [CNT_WIDTH-1:0] limit_s;
   logic                 tick_r;

   // Terminal count for the selected speed, truncated to the counter width
   always_comb begin
      limit_s = CNT_WIDTH'((TICK_DIV >> i_speed) - 32'sd1);
   end

   // Count, wrap and pulse; clear beats pause beats counting
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r  <= {CNT_WIDTH{1'b0}};
         tick_r <= 1'b0;
      end else if (i_clr) begin
         cnt_r  <= {CNT_WIDTH{1'b0}};
         tick_r <= 1'b0;
      end else if (!i_en) begin
         tick_r <= 1'b0;
      end else if (cnt_r >= limit_s) begin
         cnt_r  <= {CNT_WIDTH{1'b0}};
         tick_r <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + CNT_WIDTH'(1'b1);
         tick_r <= 1'b0;
      end
   end

   assign o_tick = tick_r;

endmodule

// File: rtl/led_seq_ctrl.sv
// 4-LED pattern sequencer: button edge detect, mode FSM, per-mode pattern
// state, free-running breathe PWM and a registered LED output that already
// reflects the state being loaded on the same edge.
module led_seq_ctrl
   import led_pkg::*;
#(
   parameter int TICK_DIV  = 12500000,
   parameter int CNT_WIDTH = 26,
   parameter int PWM_WIDTH = PWM_WIDTH_DEF
) (
   input  logic           clk,
   input  logic           rst,
   led_seq_ctrl_if.slave  bus
);

   localparam logic [LED_W-1:0]     PAT_ONE    = LED_W'(1'b1);
   localparam logic [LED_W-1:0]     BOUNCE_TOP = LED_W'(LED_W - 1);
   localparam logic [PWM_WIDTH-1:0] PWM_ONE    = PWM_WIDTH'(1'b1);
   localparam logic [PWM_WIDTH-1:0] DUTY_TOP   = {PWM_WIDTH{1'b1}};

   logic                 next_prev_r;
   logic                 rise_s;
   logic                 tick_s;
   mode_e                mode_r, mode_nx_s;
   logic [LED_W-1:0]     pat_r, pat_nx_s;     // BIN count, RUN one-hot or BOUNCE position
   logic                 bdir_r, bdir_nx_s;   // bounce direction, 1 = moving down
   logic [PWM_WIDTH-1:0] duty_r, duty_nx_s;
   logic                 wdir_r, wdir_nx_s;   // breathe direction, 1 = fading
   logic [PWM_WIDTH-1:0] pwm_r, pwm_nx_s;
   logic [LED_W-1:0]     led_r, led_nx_s;

   assign rise_s = bus.i_next & ~next_prev_r;

   led_tick_gen #(
      .TICK_DIV  (TICK_DIV),
      .CNT_WIDTH (CNT_WIDTH)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .i_en    (~bus.i_pause),
      .i_clr   (rise_s),
      .i_speed (bus.i_speed),
      .o_tick  (tick_s)
   );

   // Next mode, pattern step and LED image; a mode change discards any tick
   always_comb begin
      mode_nx_s = mode_r;
      pat_nx_s  = pat_r;
      bdir_nx_s = bdir_r;
      duty_nx_s = duty_r;
      wdir_nx_s = wdir_r;
      pwm_nx_s  = pwm_r + PWM_ONE;
      led_nx_s  = 4'b0000;

      if (rise_s) begin
         case (mode_r)
            S_BIN:     mode_nx_s = S_RUN;
            S_RUN:     mode_nx_s = S_BOUNCE;
            S_BOUNCE:  mode_nx_s = S_BREATHE;
            S_BREATHE: mode_nx_s = S_BIN;
            default:   mode_nx_s = S_BIN;
         endcase
         pat_nx_s  = init_pat(mode_nx_s);
         bdir_nx_s = 1'b0;
         duty_nx_s = {PWM_WIDTH{1'b0}};
         wdir_nx_s = 1'b0;
      end else if (tick_s) begin
         case (mode_r)
            S_BIN: pat_nx_s = pat_r + PAT_ONE;
            S_RUN: pat_nx_s = {pat_r[LED_W-2:0], pat_r[LED_W-1]};
            S_BOUNCE: begin
               if (!bdir_r) begin
                  pat_nx_s  = pat_r + PAT_ONE;
                  bdir_nx_s = (pat_r == BOUNCE_TOP - PAT_ONE);
               end else begin
                  pat_nx_s  = pat_r - PAT_ONE;
                  bdir_nx_s = (pat_r != PAT_ONE);
               end
            end
            S_BREATHE: begin
               if (!wdir_r) begin
                  duty_nx_s = duty_r + PWM_ONE;
                  wdir_nx_s = (duty_r == DUTY_TOP - PWM_ONE);
               end else begin
                  duty_nx_s = duty_r - PWM_ONE;
                  wdir_nx_s = (duty_r != PWM_ONE);
               end
            end
            default: pat_nx_s = pat_r;
         endcase
      end else begin
         pat_nx_s = pat_r;
      end

      case (mode_nx_s)
         S_BIN:     led_nx_s = pat_nx_s;
         S_RUN:     led_nx_s = pat_nx_s;
         S_BOUNCE:  led_nx_s = PAT_ONE << pat_nx_s;
         S_BREATHE: led_nx_s = {LED_W{pwm_nx_s < duty_nx_s}};
         default:   led_nx_s = 4'b0000;
      endcase
   end

   // State and output registers; button history resets high so a held button is ignored
   always_ff @(posedge clk) begin
      if (rst) begin
         next_prev_r <= 1'b1;
         mode_r      <= S_BIN;
         pat_r       <= INIT_BIN;
         bdir_r      <= 1'b0;
         duty_r      <= {PWM_WIDTH{1'b0}};
         wdir_r      <= 1'b0;
         pwm_r       <= {PWM_WIDTH{1'b0}};
         led_r       <= 4'b0000;
      end else begin
         next_prev_r <= bus.i_next;
         mode_r      <= mode_nx_s;
         pat_r       <= pat_nx_s;
         bdir_r      <= bdir_nx_s;
         duty_r      <= duty_nx_s;
         wdir_r      <= wdir_nx_s;
         pwm_r       <= pwm_nx_s;
         led_r       <= led_nx_s;
      end
   end

   assign bus.o_led  = led_r;
   assign bus.o_mode = mode_r;
   assign bus.o_tick = tick_s;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV = 8: expected LED values are
// queued as stimulus is applied and popped when the step shows on o_led.
module tb_led_seq_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic [3:0] exp_q[$];

   led_seq_ctrl_if bus ();

   led_seq_ctrl #(
      .TICK_DIV  (8),
      .CNT_WIDTH (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic check_led_pop(input string tag);
      logic [3:0] e;
      e = exp_q.pop_front();
      check(tag, {28'd0, bus.o_led}, {28'd0, e});
   endtask

   // Step until o_tick is seen (bounded); exp_n != 0 also checks the distance
   task automatic wait_tick(input int exp_n, input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (bus.o_tick !== 1'b1 && n < 100);
      check({tag, "_seen"}, {31'd0, bus.o_tick}, 32'd1);
      if (exp_n != 0) check({tag, "_dist"}, n, exp_n);
   endtask

   task automatic tick_and_check(input int exp_n, input logic [3:0] exp_led, input string tag);
      exp_q.push_back(exp_led);
      wait_tick(exp_n, tag);
      step();
      check_led_pop({tag, "_led"});
   endtask

   task automatic pulse_mode(input logic [1:0] exp_mode, input logic [3:0] exp_led, input string tag);
      bus.i_next = 1'b0;
      step();
      bus.i_next = 1'b1;
      exp_q.push_back(exp_led);
      step();
      bus.i_next = 1'b0;
      check({tag, "_mode"}, {30'd0, bus.o_mode}, {30'd0, exp_mode});
      check_led_pop({tag, "_led"});
   endtask

   // Count cycles with all LEDs on over one PWM period, plus any partial patterns
   task automatic measure_duty(input int exp_on, input string tag);
      int on_n, odd_n;
      on_n = 0;
      odd_n = 0;
      for (int i = 0; i < 16; i++) begin
         if (bus.o_led == 4'b1111) on_n++;
         else if (bus.o_led != 4'b0000) odd_n++;
         else on_n = on_n;
         step();
      end
      check({tag, "_on"}, on_n, exp_on);
      check({tag, "_odd"}, odd_n, 32'd0);
   endtask

   initial begin
      int changes, ticks, led_moves;
      logic [1:0] last_mode;
      logic [3:0] held_led;

      rst = 1'b1;
      bus.i_next  = 1'b1;
      bus.i_pause = 1'b0;
      bus.i_speed = 2'd0;
      repeat (3) step();
      check("rst_led",  {28'd0, bus.o_led},  32'd0);
      check("rst_mode", {30'd0, bus.o_mode}, 32'd0);
      check("rst_tick", {31'd0, bus.o_tick}, 32'd0);

      // Button held through reset must not advance; first tick 8 cycles after release
      rst = 1'b0;
      wait_tick(8, "first_tick");
      check("held_btn_mode", {30'd0, bus.o_mode}, 32'd0);
      bus.i_next = 1'b0;
      exp_q.push_back(4'b0001);
      step();
      check_led_pop("bin_first");
      for (int v = 2; v <= 16; v++) begin
         logic [4:0] vv;
         vv = 5'(v);
         tick_and_check(7, vv[3:0], "bin");
      end

      // Mode cycling
      pulse_mode(2'd1, 4'b0001, "to_run");
      pulse_mode(2'd2, 4'b0001, "to_bounce");
      pulse_mode(2'd3, 4'b0000, "to_breathe");
      bus.i_next = 1'b0;
      step();
      bus.i_next = 1'b1;
      changes = 0;
      last_mode = bus.o_mode;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.o_mode != last_mode) changes++;
         else changes = changes;
         last_mode = bus.o_mode;
      end
      bus.i_next = 1'b0;
      check("hold_changes", changes, 32'd1);
      check("hold_mode", {30'd0, bus.o_mode}, 32'd0);

      // RUN at speed 2: period 2, 1000 wraps to 0001
      bus.i_speed = 2'd2;
      pulse_mode(2'd1, 4'b0001, "run_entry");
      tick_and_check(2, 4'b0010, "run");
      tick_and_check(1, 4'b0100, "run");
      tick_and_check(1, 4'b1000, "run");
      tick_and_check(1, 4'b0001, "run_wrap");

      // Speed-up with cnt = 6 at speed 0 ticks on the next cycle
      bus.i_speed = 2'd0;
      repeat (5) step();
      check("cnt6_no_tick", {31'd0, bus.o_tick}, 32'd0);
      bus.i_speed = 2'd1;
      exp_q.push_back(4'b0010);
      step();
      check("speedup_tick", {31'd0, bus.o_tick}, 32'd1);
      step();
      check_led_pop("speedup_led");

      // Pause freezes ticks and pattern
      bus.i_speed = 2'd0;
      bus.i_pause = 1'b1;
      held_led = bus.o_led;
      ticks = 0;
      led_moves = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.o_tick) ticks++;
         else ticks = ticks;
         if (bus.o_led != held_led) led_moves++;
         else led_moves = led_moves;
      end
      check("pause_ticks", ticks, 32'd0);
      check("pause_led_moves", led_moves, 32'd0);
      bus.i_pause = 1'b0;

      // BOUNCE at speed 0
      pulse_mode(2'd2, 4'b0001, "bounce_entry");
      tick_and_check(8, 4'b0010, "bounce");
      tick_and_check(7, 4'b0100, "bounce");
      tick_and_check(7, 4'b1000, "bounce");
      tick_and_check(7, 4'b0100, "bounce");
      tick_and_check(7, 4'b0010, "bounce");
      tick_and_check(7, 4'b0001, "bounce");
      tick_and_check(7, 4'b0010, "bounce");
      tick_and_check(7, 4'b0100, "bounce");

      // BREATHE at speed 2, duty measured while paused (PWM keeps running)
      bus.i_speed = 2'd2;
      pulse_mode(2'd3, 4'b0000, "breathe_entry");
      repeat (15) wait_tick(2, "br_up");
      step();
      bus.i_pause = 1'b1;
      measure_duty(15, "duty15");
      bus.i_pause = 1'b0;
      wait_tick(0, "br_dn");
      step();
      bus.i_pause = 1'b1;
      measure_duty(14, "duty14");
      bus.i_pause = 1'b0;
      repeat (14) wait_tick(0, "br_dn");
      step();
      bus.i_pause = 1'b1;
      measure_duty(0, "duty0");
      check("breathe_mode", {30'd0, bus.o_mode}, 32'd3);
      bus.i_pause = 1'b0;

      // Collision: button edge during the o_tick cycle
      pulse_mode(2'd0, 4'b0000, "to_bin");
      wait_tick(2, "col1");
      bus.i_next = 1'b1;
      exp_q.push_back(4'b0001);
      step();
      bus.i_next = 1'b0;
      check("col1_mode", {30'd0, bus.o_mode}, 32'd1);
      check_led_pop("col1_led");

      // Collision: button edge while the prescaler is about to tick
      wait_tick(2, "col2");
      step();
      bus.i_next = 1'b1;
      exp_q.push_back(4'b0001);
      step();
      bus.i_next = 1'b0;
      check("col2_mode", {30'd0, bus.o_mode}, 32'd2);
      check("col2_tick", {31'd0, bus.o_tick}, 32'd0);
      check_led_pop("col2_led");

      // Reset mid-BREATHE
      pulse_mode(2'd3, 4'b0000, "to_breathe2");
      repeat (3) wait_tick(2, "br2");
      rst = 1'b1;
      step();
      check("midrst_mode", {30'd0, bus.o_mode}, 32'd0);
      check("midrst_led",  {28'd0, bus.o_led},  32'd0);
      check("midrst_tick", {31'd0, bus.o_tick}, 32'd0);
      rst = 1'b0;
      step();
      check("post_rst_mode", {30'd0, bus.o_mode}, 32'd0);
      check("post_rst_led",  {28'd0, bus.o_led},  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
